// File: rtl/nios_system_debug_ocimem_seq.sv
// On-chip debug memory access sequencer.
// Turns JTAG debug strobes into single-word RAM reads and writes. It keeps an
// auto-incrementing word address and returns read data in MonDReg.
// Optional build macro OCIMEM_WRITE_VERIFY_EN: every write is followed by a
// readback of the same word. A mismatch sets monitor_error.
module nios_system_debug_ocimem_seq #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  input  logic [31:0]       ram_rddata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_rd,
  output logic              ram_wr,
  output logic [31:0]       ram_wrdata,
  output logic [31:0]       MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error
);

  typedef enum logic [2:0] {
    IDLE,
    RD_ISSUE,
    RD_WAIT,
    WR
`ifdef OCIMEM_WRITE_VERIFY_EN
    ,
    VRD_ISSUE,
    VRD_WAIT
`endif
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   r_addr;
  logic [ADDR_W-1:0]   w_addr_nxt;
  logic                r_rd_inc;
  logic                w_rd_inc_nxt;
  logic [ADDR_W-1:0]   r_ram_addr;
  logic [ADDR_W-1:0]   w_ram_addr_nxt;
  logic                r_ram_rd;
  logic                w_ram_rd_nxt;
  logic                r_ram_wr;
  logic                w_ram_wr_nxt;
  logic [31:0]         r_ram_wrdata;
  logic [31:0]         w_ram_wrdata_nxt;
  logic [31:0]         r_mon_dreg;
  logic [31:0]         w_mon_dreg_nxt;
  logic                r_ready;
  logic                w_ready_nxt;
  logic                r_error;
  logic                w_error_nxt;

  logic                w_any_strobe;
  logic [ADDR_W-1:0]   w_jdo_addr;
  logic [ADDR_W-1:0]   w_addr_inc;
  logic                w_unused;

  assign w_any_strobe = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
  assign w_jdo_addr   = jdo[ADDR_W+25:26];
  assign w_addr_inc   = r_addr + ADDR_W'(1);
  // Operand bits that carry no meaning for this sequencer.
  assign w_unused     = ^{jdo[37:35], jdo[2:0]};

  // Register all state and RAM-side outputs; reset forces the idle/ready values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_addr       <= '0;
      r_rd_inc     <= 1'b0;
      r_ram_addr   <= '0;
      r_ram_rd     <= 1'b0;
      r_ram_wr     <= 1'b0;
      r_ram_wrdata <= '0;
      r_mon_dreg   <= '0;
      r_ready      <= 1'b1;
      r_error      <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_addr       <= w_addr_nxt;
      r_rd_inc     <= w_rd_inc_nxt;
      r_ram_addr   <= w_ram_addr_nxt;
      r_ram_rd     <= w_ram_rd_nxt;
      r_ram_wr     <= w_ram_wr_nxt;
      r_ram_wrdata <= w_ram_wrdata_nxt;
      r_mon_dreg   <= w_mon_dreg_nxt;
      r_ready      <= w_ready_nxt;
      r_error      <= w_error_nxt;
    end
  end

  // Next-state logic. The RAM strobes are computed one state ahead so that they
  // come out of flops and are high exactly while the FSM sits in the issuing state.
  always_comb begin
    w_state_nxt      = r_state;
    w_addr_nxt       = r_addr;
    w_rd_inc_nxt     = r_rd_inc;
    w_ram_addr_nxt   = r_ram_addr;
    w_ram_rd_nxt     = 1'b0;
    w_ram_wr_nxt     = 1'b0;
    w_ram_wrdata_nxt = r_ram_wrdata;
    w_mon_dreg_nxt   = r_mon_dreg;
    w_ready_nxt      = r_ready;
    w_error_nxt      = r_error;

    case (r_state)
      IDLE: begin
        if (take_action_ocimem_a) begin
          // Address load; optionally a read that leaves the address in place.
          w_addr_nxt  = w_jdo_addr;
          w_error_nxt = 1'b0;
          if (jdo[34]) begin
            w_state_nxt    = RD_ISSUE;
            w_ram_rd_nxt   = 1'b1;
            w_ram_addr_nxt = w_jdo_addr;
            w_rd_inc_nxt   = 1'b0;
            w_ready_nxt    = 1'b0;
          end
        end else if (take_action_ocimem_b) begin
          w_state_nxt      = WR;
          w_ram_wr_nxt     = 1'b1;
          w_ram_addr_nxt   = r_addr;
          w_ram_wrdata_nxt = jdo[34:3];
          w_ready_nxt      = 1'b0;
        end else if (take_no_action_ocimem_a) begin
          // Streaming read: the address advances once the data is captured.
          w_state_nxt    = RD_ISSUE;
          w_ram_rd_nxt   = 1'b1;
          w_ram_addr_nxt = r_addr;
          w_rd_inc_nxt   = 1'b1;
          w_ready_nxt    = 1'b0;
        end
      end

      RD_ISSUE: begin
        w_state_nxt = RD_WAIT;
      end

      RD_WAIT: begin
        w_mon_dreg_nxt = ram_rddata;
        w_ready_nxt    = 1'b1;
        w_state_nxt    = IDLE;
        if (r_rd_inc) begin
          w_addr_nxt = w_addr_inc;
        end
      end

      WR: begin
`ifdef OCIMEM_WRITE_VERIFY_EN
        // Read the word back from the same address.
        w_state_nxt  = VRD_ISSUE;
        w_ram_rd_nxt = 1'b1;
`else
        w_state_nxt = IDLE;
        w_ready_nxt = 1'b1;
        w_addr_nxt  = w_addr_inc;
`endif
      end

`ifdef OCIMEM_WRITE_VERIFY_EN
      VRD_ISSUE: begin
        w_state_nxt = VRD_WAIT;
      end

      VRD_WAIT: begin
        if (ram_rddata != r_ram_wrdata) begin
          w_error_nxt = 1'b1;
        end
        w_ready_nxt = 1'b1;
        w_addr_nxt  = w_addr_inc;
        w_state_nxt = IDLE;
      end
`endif

      default: begin
        w_state_nxt = IDLE;
        w_ready_nxt = 1'b1;
      end
    endcase

    // A strobe while busy is dropped. It only leaves a sticky error behind.
    if ((r_state != IDLE) && w_any_strobe) begin
      w_error_nxt = 1'b1;
    end
  end

  assign ram_addr      = r_ram_addr;
  assign ram_rd        = r_ram_rd;
  assign ram_wr        = r_ram_wr;
  assign ram_wrdata    = r_ram_wrdata;
  assign MonDReg       = r_mon_dreg;
  assign monitor_ready = r_ready;
  assign monitor_error = r_error;

endmodule

// File: tb/tb_nios_system_debug_ocimem_seq.sv
// Self-checking bench for nios_system_debug_ocimem_seq (ADDR_W = 8).
// Directed table, hand-written corner sequences, then randomized commands.
// The commands are checked against a word-level model of the debug memory.
module tb_nios_system_debug_ocimem_seq;

`ifdef OCIMEM_WRITE_VERIFY_EN
  localparam bit VERIFY = 1'b1;
`else
  localparam bit VERIFY = 1'b0;
`endif

  localparam int OP_ARD  = 0;  // ocimem_a with read
  localparam int OP_ALD  = 1;  // ocimem_a address load only
  localparam int OP_WR   = 2;  // ocimem_b
  localparam int OP_NARD = 3;  // no_action_a streaming read

  logic        clk;
  logic        reset;
  logic [37:0] jdo;
  logic        take_action_ocimem_a;
  logic        take_action_ocimem_b;
  logic        take_no_action_ocimem_a;
  logic [31:0] ram_rddata;
  logic [7:0]  ram_addr;
  logic        ram_rd;
  logic        ram_wr;
  logic [31:0] ram_wrdata;
  logic [31:0] MonDReg;
  logic        monitor_ready;
  logic        monitor_error;

  nios_system_debug_ocimem_seq #(.ADDR_W(8)) dut (
    .clk                     (clk),
    .reset                   (reset),
    .jdo                     (jdo),
    .take_action_ocimem_a    (take_action_ocimem_a),
    .take_action_ocimem_b    (take_action_ocimem_b),
    .take_no_action_ocimem_a (take_no_action_ocimem_a),
    .ram_rddata              (ram_rddata),
    .ram_addr                (ram_addr),
    .ram_rd                  (ram_rd),
    .ram_wr                  (ram_wr),
    .ram_wrdata              (ram_wrdata),
    .MonDReg                 (MonDReg),
    .monitor_ready           (monitor_ready),
    .monitor_error           (monitor_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous RAM with one cycle of read latency. It is not cleared by reset.
  logic [31:0] ram_mem [256];
  logic        ram_force_zero;
  initial ram_rddata = '0;
  always @(posedge clk) begin
    if (ram_wr) ram_mem[ram_addr] <= ram_wrdata;
    if (ram_rd) ram_rddata <= ram_force_zero ? 32'h0 : ram_mem[ram_addr];
  end

  // Reference model of the memory contents, the word address and the error flag.
  logic [31:0] exp_mem [256];
  int          m_addr;
  logic        m_err;

  int n_pass = 0;
  int n_total = 0;

  typedef struct {
    int          op;
    logic [7:0]  a;
    logic [31:0] d;
    int          exp_addr;
    logic [31:0] exp_mon;
  } vec_t;

  vec_t tbl [9];

  function automatic logic [31:0] pat(input int i);
    return 32'h5A000000 ^ (32'(i) * 32'h00010203);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h", name, act, exp);
  endtask

  // Watch the RAM port from cycle 1 after a strobe until monitor_ready returns.
  // The watch gives up after 12 cycles, and the latency is then reported as 0.
  task automatic watch(output int rd_cyc, output int rd_addr, output int wr_cyc,
                       output int wr_addr, output int rdy_cyc, output int both);
    rd_cyc = 0; rd_addr = -1; wr_cyc = 0; wr_addr = -1; rdy_cyc = 0; both = 0;
    for (int c = 1; c <= 12 && rdy_cyc == 0; c++) begin
      @(negedge clk);
      if (ram_rd && ram_wr) both = 1;
      if (ram_rd && rd_cyc == 0) begin rd_cyc = c; rd_addr = int'(ram_addr); end
      if (ram_wr && wr_cyc == 0) begin wr_cyc = c; wr_addr = int'(ram_addr); end
      if (monitor_ready) rdy_cyc = c;
    end
  endtask

  task automatic pulse(input int op, input logic [37:0] j);
    jdo = j;
    take_action_ocimem_a    = (op == OP_ARD || op == OP_ALD);
    take_action_ocimem_b    = (op == OP_WR);
    take_no_action_ocimem_a = (op == OP_NARD);
    @(posedge clk);
    #1;
    take_action_ocimem_a    = 1'b0;
    take_action_ocimem_b    = 1'b0;
    take_no_action_ocimem_a = 1'b0;
  endtask

  // Issue one command from idle (called at a falling edge), check it, then update the model.
  task automatic run_op(input string name, input int op, input logic [7:0] a,
                        input logic [31:0] d, input int exp_addr,
                        input logic [31:0] exp_mon, input logic exp_err);
    logic [37:0] j;
    int rc, ra, wc, wa, lat, both;
    j = {$urandom, $urandom};
    if (op == OP_ARD || op == OP_ALD) begin
      j[34] = (op == OP_ARD);
      j[33:26] = a;
    end else if (op == OP_WR) begin
      j[34:3] = d;
    end
    pulse(op, j);
    watch(rc, ra, wc, wa, lat, both);
    check({name, ".no_overlap"}, 64'(both), 64'd0);
    case (op)
      OP_ARD, OP_NARD: begin
        check({name, ".lat"}, 64'(lat), 64'd3);
        check({name, ".rd_cyc"}, 64'(rc), 64'd1);
        check({name, ".rd_addr"}, 64'(ra), 64'(exp_addr));
        check({name, ".wr_cyc"}, 64'(wc), 64'd0);
        check({name, ".mon"}, 64'(MonDReg), 64'(exp_mon));
      end
      OP_ALD: begin
        check({name, ".lat"}, 64'(lat), 64'd1);
        check({name, ".rd_cyc"}, 64'(rc), 64'd0);
        check({name, ".wr_cyc"}, 64'(wc), 64'd0);
      end
      default: begin
        check({name, ".lat"}, 64'(lat), VERIFY ? 64'd4 : 64'd2);
        check({name, ".wr_cyc"}, 64'(wc), 64'd1);
        check({name, ".wr_addr"}, 64'(wa), 64'(exp_addr));
        check({name, ".rd_cyc"}, 64'(rc), VERIFY ? 64'd2 : 64'd0);
        if (VERIFY) check({name, ".vrd_addr"}, 64'(ra), 64'(exp_addr));
      end
    endcase
    check({name, ".err"}, 64'(monitor_error), 64'(exp_err));
    case (op)
      OP_ARD, OP_ALD: begin m_addr = int'(a); m_err = 1'b0; end
      OP_WR: begin exp_mem[m_addr] = d; m_addr = (m_addr + 1) % 256; end
      default: m_addr = (m_addr + 1) % 256;
    endcase
  endtask

  initial begin
    int rc, ra, wc, wa, lat, both;
    int op;
    logic [7:0] a;
    logic [31:0] d;
    int wr_at;

    for (int i = 0; i < 256; i++) begin
      ram_mem[i] = pat(i);
      exp_mem[i] = pat(i);
    end
    ram_mem[8'h10] = 32'hDEADBEEF; exp_mem[8'h10] = 32'hDEADBEEF;
    ram_mem[8'hFF] = 32'hCAFE00FF; exp_mem[8'hFF] = 32'hCAFE00FF;
    ram_force_zero = 1'b0;
    m_addr = 0;
    m_err = 1'b0;

    tbl[0] = '{OP_ARD,  8'h10, 32'h0,        'h10, 32'hDEADBEEF};
    tbl[1] = '{OP_WR,   8'h00, 32'h11111111, 'h10, 32'h0};
    tbl[2] = '{OP_WR,   8'h00, 32'h22222222, 'h11, 32'h0};
    tbl[3] = '{OP_NARD, 8'h00, 32'h0,        'h12, pat('h12)};
    tbl[4] = '{OP_ALD,  8'hFF, 32'h0,        -1,   32'h0};
    tbl[5] = '{OP_NARD, 8'h00, 32'h0,        'hFF, 32'hCAFE00FF};
    tbl[6] = '{OP_NARD, 8'h00, 32'h0,        'h00, pat(0)};
    tbl[7] = '{OP_ARD,  8'h10, 32'h0,        'h10, 32'h11111111};
    tbl[8] = '{OP_ARD,  8'h11, 32'h0,        'h11, 32'h22222222};

    // Asynchronous reset is checked before any clock edge.
    jdo = '0;
    take_action_ocimem_a = 1'b0;
    take_action_ocimem_b = 1'b0;
    take_no_action_ocimem_a = 1'b0;
    reset = 1'b1;
    #2;
    check("rst.ram_rd", 64'(ram_rd), 64'd0);
    check("rst.ram_wr", 64'(ram_wr), 64'd0);
    check("rst.ram_addr", 64'(ram_addr), 64'd0);
    check("rst.ram_wrdata", 64'(ram_wrdata), 64'd0);
    check("rst.mon", 64'(MonDReg), 64'd0);
    check("rst.ready", 64'(monitor_ready), 64'd1);
    check("rst.err", 64'(monitor_error), 64'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Directed table: load/read, write burst, streaming read and address wrap.
    for (int i = 0; i < 9; i++)
      run_op($sformatf("tbl%0d", i), tbl[i].op, tbl[i].a, tbl[i].d,
             tbl[i].exp_addr, tbl[i].exp_mon, 1'b0);

    // A write strobe one cycle into a read is dropped and flags an error.
    d = 32'h33333333;
    wr_at = m_addr;
    pulse(OP_NARD, 38'h0);
    pulse(OP_WR, {3'b0, d, 3'b0});
    watch(rc, ra, wc, wa, lat, both);
    check("busy.ready", 64'(lat != 0), 64'd1);
    check("busy.no_wr", 64'(wc), 64'd0);
    check("busy.err", 64'(monitor_error), 64'd1);
    check("busy.mon", 64'(MonDReg), 64'(exp_mem[wr_at]));
    m_addr = (m_addr + 1) % 256;
    m_err = 1'b1;
    run_op("busy.clear", OP_ALD, 8'h20, 32'h0, -1, 32'h0, 1'b0);

    // ocimem_a and ocimem_b together: only the address/read command acts.
    jdo = '0; jdo[34] = 1'b1; jdo[33:26] = 8'h30;
    take_action_ocimem_a = 1'b1;
    take_action_ocimem_b = 1'b1;
    @(posedge clk);
    #1;
    take_action_ocimem_a = 1'b0;
    take_action_ocimem_b = 1'b0;
    watch(rc, ra, wc, wa, lat, both);
    check("prio.lat", 64'(lat), 64'd3);
    check("prio.rd_addr", 64'(ra), 64'h30);
    check("prio.no_wr", 64'(wc), 64'd0);
    check("prio.err", 64'(monitor_error), 64'd0);
    check("prio.mon", 64'(MonDReg), 64'(exp_mem[8'h30]));
    m_addr = 'h30;

    // Reset in the middle of a write: the strobe drops at once and the word is untouched.
    wr_at = m_addr;
    pulse(OP_WR, {3'b0, 32'h44444444, 3'b0});
    @(negedge clk);
    check("abort.wr_before", 64'(ram_wr), 64'd1);
    #1;
    reset = 1'b1;
    #1;
    check("abort.ram_wr", 64'(ram_wr), 64'd0);
    check("abort.ram_rd", 64'(ram_rd), 64'd0);
    check("abort.ram_addr", 64'(ram_addr), 64'd0);
    check("abort.ram_wrdata", 64'(ram_wrdata), 64'd0);
    check("abort.mon", 64'(MonDReg), 64'd0);
    check("abort.ready", 64'(monitor_ready), 64'd1);
    check("abort.err", 64'(monitor_error), 64'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    m_addr = 0;
    m_err = 1'b0;
    run_op("abort.readback", OP_ARD, 8'(wr_at), 32'h0, wr_at, exp_mem[wr_at], 1'b0);

`ifdef OCIMEM_WRITE_VERIFY_EN
    // The readback differs from the written word, so monitor_error must be set.
    ram_force_zero = 1'b1;
    run_op("verify.mismatch", OP_WR, 8'h0, 32'h5A5A5A5A, m_addr, 32'h0, 1'b1);
    m_err = 1'b1;
    ram_force_zero = 1'b0;
`endif

    // Randomized command stream against the model.
    for (int i = 0; i < 40; i++) begin
      op = int'($urandom_range(0, 3));
      a = 8'($urandom);
      d = $urandom;
      if (op == OP_ARD)
        run_op($sformatf("rnd%0d", i), op, a, d, int'(a), exp_mem[a], 1'b0);
      else if (op == OP_ALD)
        run_op($sformatf("rnd%0d", i), op, a, d, -1, 32'h0, 1'b0);
      else
        run_op($sformatf("rnd%0d", i), op, a, d, m_addr, exp_mem[m_addr], m_err);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/nios_system_debug_ocimem_seq.md
NIOS_SYSTEM_DEBUG_OCIMEM_SEQ -- requirements
Module: nios_system_debug_ocimem_seq

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, RAM word-address width.
REQ-002 SHALL have port clk, input, 1: sole clock; all state is updated on the rising edge.
REQ-003 SHALL have port reset, input, 1: asynchronous, active-high reset; one clock; reset is asynchronous and active-high.
REQ-004 SHALL have port jdo, input, 38: JTAG debug operand, already synchronized to clk.
REQ-005 SHALL have port take_action_ocimem_a, input, 1: single-cycle strobe, load address and optionally read.
REQ-006 SHALL have port take_action_ocimem_b, input, 1: single-cycle strobe, write data.
REQ-007 SHALL have port take_no_action_ocimem_a, input, 1: single-cycle strobe, read at the current address.
REQ-008 SHALL have port ram_rddata, input, 32: RAM read data, valid 1 cycle after ram_rd.
REQ-009 SHALL have port ram_addr, output, ADDR_W: RAM word address.
REQ-010 SHALL have port ram_rd, output, 1: RAM read strobe.
REQ-011 SHALL have port ram_wr, output, 1: RAM write strobe.
REQ-012 SHALL have port ram_wrdata, output, 32: RAM write data.
REQ-013 SHALL have port MonDReg, output, 32: last read data, returned to the debug TCK stage.
REQ-014 SHALL have port monitor_ready, output, 1: sequencer idle and the previous result is valid.
REQ-015 SHALL have port monitor_error, output, 1: sticky command error.

Function
REQ-016 SHALL implement FSM states IDLE, RD_ISSUE, RD_WAIT and WR, plus VRD_ISSUE and VRD_WAIT when compiled in (REQ-031).
REQ-017 SHALL sample strobes only in IDLE, with priority ocimem_a > ocimem_b > no_action_a; a lower-priority strobe in the same cycle is dropped without error.
REQ-018 ocimem_a SHALL load the address register from jdo[ADDR_W+25:26] and clear monitor_error.
- jdo[34]=1: go to RD_ISSUE.
- jdo[34]=0: stay IDLE; monitor_ready stays 1.
REQ-019 ocimem_b SHALL latch jdo[34:3] as write data and go to WR.
REQ-020 no_action_a SHALL go to RD_ISSUE.
REQ-021 RD_ISSUE SHALL drive ram_rd=1 and ram_addr=address register for one cycle, then go to RD_WAIT.
REQ-022 RD_WAIT SHALL register ram_rddata into MonDReg and go to IDLE. MonDReg and monitor_ready=1 become visible 3 cycles after the strobe cycle.
REQ-023 WR SHALL drive ram_wr=1, ram_addr and ram_wrdata for one cycle, then go to IDLE; monitor_ready=1 is visible 2 cycles after the strobe.
REQ-024 The address register SHALL post-increment by 1 on leaving RD_WAIT for no_action_a, and on leaving WR; it SHALL NOT increment for an ocimem_a read.
REQ-025 Address increment SHALL wrap modulo 2^ADDR_W, so address 255 increments to 0 when ADDR_W=8.
REQ-026 monitor_ready SHALL be registered, cleared in the cycle after a strobe is accepted, and 1 in IDLE otherwise.
REQ-027 Any strobe arriving outside IDLE SHALL be dropped and SHALL set monitor_error=1; the FSM and address register are unaffected.
REQ-028 ram_rd and ram_wr SHALL never both be 1 in the same cycle.

Reset
REQ-029 While reset=1, asynchronously and with no clock required, the block SHALL hold:
- FSM in IDLE;
- address register = 0;
- MonDReg = 0;
- ram_addr, ram_wrdata = 0;
- ram_rd, ram_wr = 0;
- monitor_ready = 1;
- monitor_error = 0.
REQ-030 Reset asserted mid-operation SHALL abort the operation; a pending RAM write SHALL NOT complete.

Configuration
REQ-031 Macro OCIMEM_WRITE_VERIFY_EN:
- Defined: WR is followed by VRD_ISSUE, then VRD_WAIT, then IDLE; the readback is compared with the written data and monitor_error is set on mismatch; the address increments on leaving VRD_WAIT; monitor_ready is visible 4 cycles after the strobe; MonDReg is unchanged.
- Undefined: the VRD states are absent and the REQ-023 timing applies.

Verification
REQ-032 Load and read: reset; ocimem_a with jdo[33:26]=0x10 and jdo[34]=1; RAM[0x10]=0xDEADBEEF -> ram_rd at cycle 1 with addr 0x10; MonDReg=0xDEADBEEF and monitor_ready=1 at cycle 3; address stays 0x10.
REQ-033 Write burst: ocimem_b with data 0x11111111, then 0x22222222 after ready -> ram_wr at addr 0x10, then 0x11; address ends at 0x12.
REQ-034 Wrap: address 0xFF, no_action_a -> read from 0xFF; address becomes 0x00.
REQ-035 Busy and priority:
- ocimem_b one cycle after no_action_a -> write dropped; monitor_error=1; next ocimem_a clears the error.
- ocimem_a and ocimem_b in the same cycle -> only ocimem_a acts; no error.
REQ-036 Reset abort: assert reset during WR -> ram_wr=0 immediately; all outputs at reset values; monitor_ready=1.
REQ-037 With OCIMEM_WRITE_VERIFY_EN defined and RAM forced to return 0x0 after writing 0x5A5A5A5A -> monitor_error=1 and monitor_ready=1 at cycle 4.
